iq_issue_ctrl: RTL and testbench

In-order multi-issue controller for the instruction-queue circular buffer. Each cycle it examines the EXT_COUNT head slots, checks register readiness against a scoreboard, intra-group hazards and functional-unit limits, and issues the longest legal in-order prefix. It drives the buffer's `ext_enable`/`ext_consumed` and per-lane issue strobes to the execute stage. It sits between the issue queue and the functional units, and its scoreboard is cleared by writeback.

---
 rtl/iq_issue_ctrl_pkg.sv | 44 ++++
 rtl/iq_issue_ctrl_scoreboard.sv | 61 ++++++
 rtl/iq_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_iq_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipTypes
// Shared types and sizing for the instruction-queue issue controller.
//   EXT_COUNT    : head slots examined per cycle (maximum issue width)
//   NREGS        : architectural registers tracked by the scoreboard
//   WB_PORTS     : writeback ports clearing the scoreboard
//   MUL_LAT      : occupancy of the non-pipelined multiplier in cycles
//   fu_class_t   : functional-unit class of a decoded slot
//   iss_slot_t   : per-slot decode presented by the issue queue
//   ctrl_state_t : controller state (normal issue or post-flush recovery)
// ---------------------------------------------------------------------------
package pipTypes;

  localparam int EXT_COUNT    = 4;
  localparam int NREGS        = 32;
  localparam int WB_PORTS     = 2;
  localparam int MUL_LAT      = 4;
  localparam int EXTCOUNTLOG2 = $clog2(EXT_COUNT);
  localparam int REGLOG2      = $clog2(NREGS);
  localparam int MULCNTW      = $clog2(MUL_LAT);

  typedef enum logic [1:0] {
    ALU    = 2'd0,
    MUL    = 2'd1,
    MEM    = 2'd2,
    BRANCH = 2'd3
  } fu_class_t;

  typedef struct packed {
    logic [REGLOG2-1:0] src_a;
    logic [REGLOG2-1:0] src_b;
    logic               uses_a;
    logic               uses_b;
    logic [REGLOG2-1:0] dest;
    logic               writes;
    fu_class_t          cls;
  } iss_slot_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/iq_issue_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// iss_scoreboard
// Pending-write bit vector with same-cycle writeback bypass on its queries.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   flush          : clears every pending bit at the clock edge
//   i_wbValid/Dest : writeback strobes and registers; clear pending bits
//   i_setMask      : registers becoming pending at this edge (set wins)
//   i_qReg         : registers being queried
//   o_qReady       : query result, 1 = register 0, not pending, or bypassed
// ---------------------------------------------------------------------------
module iss_scoreboard
  import pipTypes::*;
#(
  parameter int NQ = 3 * EXT_COUNT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [WB_PORTS-1:0]                i_wbValid,
  input  logic [WB_PORTS-1:0][REGLOG2-1:0]   i_wbDest,
  input  logic [NREGS-1:0]                   i_setMask,
  input  logic [NQ-1:0][REGLOG2-1:0]         i_qReg,
  output logic [NQ-1:0]                      o_qReady
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_clrMask;
  logic [NREGS-1:0] w_nextPending;

  // Decode the writeback ports into a one-hot-per-register clear mask.
  always_comb begin
    w_clrMask = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (i_wbValid[p]) w_clrMask[i_wbDest[p]] = 1'b1;
    end
  end

  // A writeback landing this cycle makes its register ready immediately.
  always_comb begin
    o_qReady = '0;
    for (int q = 0; q < NQ; q++) begin
      o_qReady[q] = (i_qReg[q] == '0) || !r_pending[i_qReg[q]] ||
                    w_clrMask[i_qReg[q]];
    end
  end

  // Clear first, then set, so a new issue to a register outranks its
  // own older writeback; register 0 is forced never-pending.
  assign w_nextPending = ((r_pending & ~w_clrMask) | i_setMask) & ~NREGS'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
    end else if (flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_nextPending;
    end
  end

endmodule

// File: rtl/iq_issue_ctrl.sv
// ---------------------------------------------------------------------------
// iq_issue_ctrl
// In-order multi-issue controller: issues the longest legal prefix of the
// issue-queue head slots each cycle.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   iq_valid      : head-slot valid, lane 0 oldest
//   slots         : per-slot decode
//   issue_ok      : execute stage accepts a group this cycle
//   wb_valid/dest : writeback strobes clearing the scoreboard
//   flush         : pipeline flush, enters RECOVER
//   ext_enable    : pop request to the buffer
//   ext_consumed  : issue count minus one (0 when nothing issues)
//   issue_valid   : per-lane issue strobes, always a contiguous prefix
//   stall_cycles  : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module iq_issue_ctrl
  import pipTypes::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic [EXT_COUNT-1:0]              iq_valid,
  input  iss_slot_t [EXT_COUNT-1:0]         slots,
  input  logic                              issue_ok,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS-1:0][REGLOG2-1:0]  wb_dest,
  input  logic                              flush,
  output logic                              ext_enable,
  output logic [EXTCOUNTLOG2-1:0]           ext_consumed,
  output logic [EXT_COUNT-1:0]              issue_valid,
  output logic [31:0]                       stall_cycles
);

  ctrl_state_t r_state;
  logic [MULCNTW-1:0] r_mulCnt;
  logic [31:0] r_stall;

  logic [3*EXT_COUNT-1:0][REGLOG2-1:0] w_qReg;
  logic [3*EXT_COUNT-1:0] w_qReady;
  logic [NREGS-1:0] w_setMask;
  logic [NREGS-1:0] w_claimed;
  logic [EXT_COUNT-1:0] w_issue;
  logic w_go, w_laneOk, w_memSeen, w_mulSeen;
  logic [EXTCOUNTLOG2:0] w_n;
  logic [EXTCOUNTLOG2:0] w_nMinus1;

  // Each lane queries its two sources and its destination.
  always_comb begin
    w_qReg = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      w_qReg[3*i]   = slots[i].src_a;
      w_qReg[3*i+1] = slots[i].src_b;
      w_qReg[3*i+2] = slots[i].dest;
    end
  end

  iss_scoreboard #(.NQ(3 * EXT_COUNT)) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .i_wbValid (wb_valid),
    .i_wbDest  (wb_dest),
    .i_setMask (w_setMask),
    .i_qReg    (w_qReg),
    .o_qReady  (w_qReady)
  );

  // Prefix chain: w_go drops at the first lane that cannot issue or after a
  // branch, so issue_valid is contiguous by construction. w_claimed holds
  // destinations written by earlier issuing lanes of the same group.
  always_comb begin
    w_issue   = '0;
    w_claimed = '0;
    w_setMask = '0;
    w_memSeen = 1'b0;
    w_mulSeen = 1'b0;
    w_laneOk  = 1'b0;
    w_go      = (r_state == RUN) && !flush && issue_ok && !reset;
    for (int i = 0; i < EXT_COUNT; i++) begin
      w_laneOk = w_go && iq_valid[i];
      if (slots[i].uses_a && (!w_qReady[3*i] || w_claimed[slots[i].src_a]))
        w_laneOk = 1'b0;
      if (slots[i].uses_b && (!w_qReady[3*i+1] || w_claimed[slots[i].src_b]))
        w_laneOk = 1'b0;
      if (slots[i].writes && (!w_qReady[3*i+2] || w_claimed[slots[i].dest]))
        w_laneOk = 1'b0;
      if (slots[i].cls == MEM && w_memSeen)
        w_laneOk = 1'b0;
      if (slots[i].cls == MUL && (w_mulSeen || r_mulCnt != '0))
        w_laneOk = 1'b0;
      if (w_laneOk) begin
        w_issue[i] = 1'b1;
        if (slots[i].writes && slots[i].dest != '0) begin
          w_claimed[slots[i].dest] = 1'b1;
          w_setMask[slots[i].dest] = 1'b1;
        end
        if (slots[i].cls == MEM) w_memSeen = 1'b1;
        if (slots[i].cls == MUL) w_mulSeen = 1'b1;
        if (slots[i].cls == BRANCH) w_go = 1'b0;
      end else begin
        w_go = 1'b0;
      end
    end
  end

  // Issue count feeds the buffer pop interface.
  always_comb begin
    w_n = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      w_n = w_n + {{EXTCOUNTLOG2{1'b0}}, w_issue[i]};
    end
  end

  assign w_nMinus1    = w_n - 1'b1;
  assign ext_enable   = (w_n != '0);
  assign ext_consumed = ext_enable ? w_nMinus1[EXTCOUNTLOG2-1:0] : '0;
  assign issue_valid  = w_issue;
  assign stall_cycles = r_stall;

  // Controller state, multiplier occupancy and stall counter. Flush takes
  // the controller to RECOVER for one cycle and frees the multiplier; the
  // stall counter survives flushes and is cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= RUN;
      r_mulCnt <= '0;
      r_stall  <= '0;
    end else begin
      if (flush) begin
        r_state  <= RECOVER;
        r_mulCnt <= '0;
      end else begin
        r_state <= RUN;
        if (w_mulSeen)
          r_mulCnt <= MULCNTW'(MUL_LAT - 1);
        else if (r_mulCnt != '0)
          r_mulCnt <= r_mulCnt - 1'b1;
      end
      if (r_state == RUN && !flush && iq_valid[0] && w_n == '0 &&
          r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iq_issue_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the issue rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_iq_issue_ctrl;
  import pipTypes::*;

  logic clock = 1'b0;
  logic reset;
  logic [EXT_COUNT-1:0] iq_valid;
  iss_slot_t [EXT_COUNT-1:0] slots;
  logic issue_ok;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS-1:0][REGLOG2-1:0] wb_dest;
  logic flush;
  logic ext_enable;
  logic [EXTCOUNTLOG2-1:0] ext_consumed;
  logic [EXT_COUNT-1:0] issue_valid;
  logic [31:0] stall_cycles;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state: which registers await writeback, cycles the
  // multiplier stays busy, whether this is the recovery cycle, stall count.
  bit mPend[NREGS];
  int mMulBusy;
  bit mRecover;
  logic [31:0] mStall;
  logic [31:0] stallRef;

  iq_issue_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .iq_valid     (iq_valid),
    .slots        (slots),
    .issue_ok     (issue_ok),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .flush        (flush),
    .ext_enable   (ext_enable),
    .ext_consumed (ext_consumed),
    .issue_valid  (issue_valid),
    .stall_cycles (stall_cycles)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic iss_slot_t mk(fu_class_t c, int d, bit w, int a, bit ua,
                                   int b, bit ub);
    iss_slot_t s;
    s.cls    = c;
    s.dest   = REGLOG2'(d);
    s.writes = w;
    s.src_a  = REGLOG2'(a);
    s.uses_a = ua;
    s.src_b  = REGLOG2'(b);
    s.uses_b = ub;
    return s;
  endfunction

  // A register can be read or overwritten when it is r0, not awaiting a
  // writeback, or being written back right now.
  function automatic bit regFree(logic [REGLOG2-1:0] r);
    if (r == 0 || !mPend[r]) return 1'b1;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && wb_dest[p] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Number of lanes the rules allow to issue with the current inputs.
  function automatic int modelIssue();
    bit claimed[NREGS];
    int n = 0;
    bit memSeen = 1'b0;
    bit mulSeen = 1'b0;
    if (reset || flush || mRecover || !issue_ok) return 0;
    for (int r = 0; r < NREGS; r++) claimed[r] = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!iq_valid[i]) break;
      if (slots[i].uses_a && (!regFree(slots[i].src_a) ||
          (slots[i].src_a != 0 && claimed[slots[i].src_a]))) break;
      if (slots[i].uses_b && (!regFree(slots[i].src_b) ||
          (slots[i].src_b != 0 && claimed[slots[i].src_b]))) break;
      if (slots[i].writes && slots[i].dest != 0 &&
          (!regFree(slots[i].dest) || claimed[slots[i].dest])) break;
      if (slots[i].cls == MEM && memSeen) break;
      if (slots[i].cls == MUL && (mulSeen || mMulBusy > 0)) break;
      n++;
      if (slots[i].writes && slots[i].dest != 0) claimed[slots[i].dest] = 1'b1;
      if (slots[i].cls == MEM) memSeen = 1'b1;
      if (slots[i].cls == MUL) mulSeen = 1'b1;
      if (slots[i].cls == BRANCH) break;
    end
    return n;
  endfunction

  // Advance the model across one clock edge using the held inputs.
  task automatic modelUpdate();
    int n;
    bit mulIss;
    n = modelIssue();
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mPend[r] = 1'b0;
      mMulBusy = 0;
      mRecover = 1'b0;
      mStall   = 0;
    end else if (flush) begin
      for (int r = 0; r < NREGS; r++) mPend[r] = 1'b0;
      mMulBusy = 0;
      mRecover = 1'b1;
    end else begin
      if (!mRecover && iq_valid[0] && n == 0 && mStall != 32'hFFFF_FFFF)
        mStall = mStall + 1;
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p]) mPend[wb_dest[p]] = 1'b0;
      mulIss = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (slots[i].writes && slots[i].dest != 0) mPend[slots[i].dest] = 1'b1;
        if (slots[i].cls == MUL) mulIss = 1'b1;
      end
      if (mulIss) mMulBusy = MUL_LAT - 1;
      else if (mMulBusy > 0) mMulBusy--;
      mRecover = 1'b0;
    end
  endtask

  // Compare outputs against the model mid-cycle, optionally against a
  // hand-derived issue pattern, then cross the next rising edge.
  task automatic applyStimulus(input string tag, input int dirIssue);
    int n;
    logic [31:0] expIv;
    #1;
    n = modelIssue();
    expIv = (n == 0) ? 32'd0 : ((32'd1 << n) - 32'd1);
    checkOutput({tag, "_iv"}, 32'(issue_valid), expIv);
    checkOutput({tag, "_en"}, 32'(ext_enable), (n > 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_cons"}, 32'(ext_consumed), (n > 0) ? 32'(n - 1) : 32'd0);
    checkOutput({tag, "_stall"}, stall_cycles, mStall);
    if (dirIssue >= 0) checkOutput({tag, "_dir"}, 32'(issue_valid), 32'(dirIssue));
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  task automatic idle();
    iq_valid = '0;
    slots    = '0;
    issue_ok = 1'b1;
    wb_valid = '0;
    wb_dest  = '0;
    flush    = 1'b0;
  endtask

  task automatic writeBack(input int r0, input int r1);
    iq_valid   = '0;
    wb_valid   = 2'b11;
    wb_dest[0] = REGLOG2'(r0);
    wb_dest[1] = REGLOG2'(r1);
    applyStimulus("wb", 0);
    wb_valid = '0;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) mPend[r] = 1'b0;
    mMulBusy = 0;
    mRecover = 1'b0;
    mStall   = 0;
    idle();
    reset = 1'b1;
    @(negedge clock);
    applyStimulus("rst0", 0);
    iq_valid = 4'hF;
    applyStimulus("rst1", 0);
    reset = 1'b0;
    idle();

    // Four independent ALU ops issue together and leave their dests pending.
    slots[0] = mk(ALU, 1, 1, 0, 0, 0, 0);
    slots[1] = mk(ALU, 2, 1, 0, 0, 0, 0);
    slots[2] = mk(ALU, 3, 1, 0, 0, 0, 0);
    slots[3] = mk(ALU, 4, 1, 0, 0, 0, 0);
    iq_valid = 4'hF;
    applyStimulus("alu4", 4'hF);
    applyStimulus("alu4pend", 0);
    writeBack(1, 2);
    writeBack(3, 4);

    // Read-after-write inside a group, then the same-cycle bypass.
    slots[0] = mk(ALU, 5, 1, 0, 0, 0, 0);
    slots[1] = mk(ALU, 6, 1, 5, 1, 0, 0);
    iq_valid = 4'b0011;
    applyStimulus("raw", 4'b0001);
    slots[0] = slots[1];
    iq_valid = 4'b0001;
    applyStimulus("rawwait", 0);
    wb_valid   = 2'b01;
    wb_dest[0] = 5'd5;
    applyStimulus("bypass", 4'b0001);
    writeBack(6, 0);

    // Second MUL waits out the multiplier occupancy.
    slots[0] = mk(MUL, 8, 1, 0, 0, 0, 0);
    slots[1] = mk(ALU, 9, 1, 0, 0, 0, 0);
    slots[2] = mk(MUL, 10, 1, 0, 0, 0, 0);
    slots[3] = mk(ALU, 11, 1, 0, 0, 0, 0);
    iq_valid = 4'hF;
    applyStimulus("mul2", 4'b0011);
    slots[0] = mk(MUL, 10, 1, 0, 0, 0, 0);
    iq_valid = 4'b0001;
    for (int k = 0; k < MUL_LAT - 1; k++) applyStimulus("mulblk", 0);
    applyStimulus("mulgo", 4'b0001);
    writeBack(8, 9);
    writeBack(10, 0);

    // A branch closes the group.
    slots[0] = mk(ALU, 11, 1, 0, 0, 0, 0);
    slots[1] = mk(BRANCH, 0, 0, 0, 0, 0, 0);
    slots[2] = mk(ALU, 12, 1, 0, 0, 0, 0);
    slots[3] = mk(ALU, 13, 1, 0, 0, 0, 0);
    iq_valid = 4'hF;
    applyStimulus("branch", 4'b0011);
    writeBack(11, 0);

    // Flush with r7's writeback in flight; r9 is only cleared by the flush.
    slots[0] = mk(ALU, 7, 1, 0, 0, 0, 0);
    slots[1] = mk(ALU, 9, 1, 0, 0, 0, 0);
    iq_valid = 4'b0011;
    applyStimulus("preflush", 4'b0011);
    slots[0]   = mk(ALU, 14, 1, 0, 0, 0, 0);
    iq_valid   = 4'b0001;
    flush      = 1'b1;
    wb_valid   = 2'b01;
    wb_dest[0] = 5'd7;
    stallRef   = mStall;
    applyStimulus("flush", 0);
    flush    = 1'b0;
    wb_valid = '0;
    applyStimulus("recover", 0);
    checkOutput("flushstall", stall_cycles, stallRef);
    slots[0] = mk(ALU, 14, 1, 9, 1, 7, 1);
    applyStimulus("postflush", 4'b0001);
    writeBack(14, 0);

    // Ten stalled cycles on a pending source, then reset mid-stall.
    slots[0] = mk(ALU, 15, 1, 0, 0, 0, 0);
    iq_valid = 4'b0001;
    applyStimulus("mkpend", 4'b0001);
    slots[0] = mk(ALU, 16, 1, 15, 1, 0, 0);
    stallRef = mStall;
    for (int k = 0; k < 10; k++) applyStimulus("stall", 0);
    checkOutput("stall10", stall_cycles, stallRef + 32'd10);
    reset = 1'b1;
    applyStimulus("midrst", 0);
    reset = 1'b0;
    checkOutput("rstclr", stall_cycles, 32'd0);
    iq_valid = '0;
    applyStimulus("rstidle", 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < EXT_COUNT; i++) begin
        slots[i] = mk(fu_class_t'($urandom_range(0, 3)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)));
        iq_valid[i] = ($urandom_range(0, 9) < 8);
      end
      issue_ok = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p] = ($urandom_range(0, 1) == 1);
        wb_dest[p]  = REGLOG2'($urandom_range(0, 7));
      end
      applyStimulus("rand", -1);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
